// File: rtl/ahb_mem_slave.sv
// ahb_mem_slave: AHB-Lite memory slave with a pipelined address/data phase,
// little-endian byte/halfword/word lanes, WAIT_STATES wait cycles per OKAY
// transfer and an optional two-cycle ERROR response.
// Optional feature macro: AHB_MEM_ERR_EN (illegal-transfer detection/ERROR).
// Ports:
//   hclk, hresetn      bus clock, asynchronous active-low reset
//   hsel, haddr,       address phase: select, byte address,
//   htrans, hwrite,    transfer type, direction,
//   hsize, hready      size (2^hsize bytes), bus-level ready
//   hwdata             write data, sampled in the data phase
//   hreadyout, hresp,  this slave's ready, response (00 OKAY, 01 ERROR),
//   hrdata             read data (zero outside a read access cycle)
module ahb_mem_slave #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              hsel,
    input  logic [31:0]       haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    output logic              hreadyout,
    output logic [1:0]        hresp,
    output logic [DATA_W-1:0] hrdata
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned LG_NB = $clog2(NB);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [2:0]  MAX_SZ = 3'(LG_NB);
`ifdef AHB_MEM_ERR_EN
    localparam logic [32:0] SPAN  = 33'(DEPTH * NB);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
`ifdef AHB_MEM_ERR_EN
        ST_ERR1,
        ST_ERR2,
`endif
        ST_ACCESS
    } state_t;

    state_t             r_state;
    state_t             w_next;
    state_t             w_first;
    logic [3:0]         r_cnt;
    logic               r_write;
    logic [2:0]         r_size;
    logic [LG_NB-1:0]   r_off;
    logic [AW-1:0]      r_idx;

    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic               w_accept;
    logic               w_take;
    logic [31:0]        w_rel;
    logic [2:0]         w_size;
    logic [LG_NB-1:0]   w_off;
    logic [AW-1:0]      w_idx;
    logic [NB-1:0]      w_be;
    logic               w_we;
    logic               w_unused_trans;
`ifdef AHB_MEM_ERR_EN
    logic [7:0]         w_amask;
    logic               w_illegal;
`endif

    // BUSY vs IDLE and NONSEQ vs SEQ differ only in htrans[0]; the slave
    // treats both pairs identically.
    assign w_unused_trans = htrans[0];

    assign w_accept = hsel & hready & htrans[1];
    // Only sample an address phase when this slave can end its own data
    // phase on this edge (IDLE, ACCESS or ERR2).
    assign w_take   = w_accept & hreadyout;

    assign w_rel  = haddr - BASE_ADDR;
    assign w_idx  = AW'(w_rel >> LG_NB);
    // Oversized transfers collapse to a full-width access.
    assign w_size = (hsize > MAX_SZ) ? MAX_SZ : hsize;
    // Align the lane offset down to the transfer size.
    assign w_off  = haddr[LG_NB-1:0]
                  & ~LG_NB'((8'd1 << w_size) - 8'd1);

`ifdef AHB_MEM_ERR_EN
    assign w_amask   = (8'd1 << hsize) - 8'd1;
    assign w_illegal = (hsize > MAX_SZ)
                     | ((haddr[7:0] & w_amask) != 8'd0)
                     | (haddr < BASE_ADDR)
                     | ({1'b0, w_rel} >= SPAN);
`endif

    always_comb begin
        w_first = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
`ifdef AHB_MEM_ERR_EN
        if (w_illegal) begin
            w_first = ST_ERR1;
        end
`endif
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    w_next = w_first;
                end
            end
            ST_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_next = w_take ? w_first : ST_IDLE;
            end
`ifdef AHB_MEM_ERR_EN
            ST_ERR1: begin
                w_next = ST_ERR2;
            end
            ST_ERR2: begin
                w_next = w_take ? w_first : ST_IDLE;
            end
`endif
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_size  <= 3'd0;
            r_off   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            if (w_take) begin
                r_write <= hwrite;
                r_size  <= w_size;
                r_off   <= w_off;
                r_idx   <= w_idx;
            end
            if (w_take && (w_first == ST_WAIT)) begin
                r_cnt <= 4'(WAIT_STATES);
            end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        hreadyout = 1'b1;
        hresp     = 2'b00;
        hrdata    = '0;
        unique case (r_state)
            ST_WAIT: begin
                hreadyout = (r_cnt == 4'd0);
            end
            ST_ACCESS: begin
                if (!r_write) begin
                    hrdata = r_mem[r_idx];
                end
            end
`ifdef AHB_MEM_ERR_EN
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 2'b01;
            end
            ST_ERR2: begin
                hresp     = 2'b01;
            end
`endif
            default: begin
                hreadyout = 1'b1;
            end
        endcase
    end

    // Byte enables: 2^size bytes starting at the registered lane offset.
    always_comb begin
        w_be = '0;
        for (int b = 0; b < NB; b++) begin
            w_be[b] = (b >= int'(r_off))
                   && (b < int'(r_off) + (1 << r_size));
        end
    end

    // The async reset clears r_state at once, so a reset that lands in
    // ST_ACCESS suppresses the commit on the following edge.
    assign w_we = (r_state == ST_ACCESS) & r_write;

    always_ff @(posedge hclk) begin
        if (w_we) begin
            for (int b = 0; b < NB; b++) begin
                if (w_be[b]) begin
                    r_mem[r_idx][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

endmodule
